ttt_board_engine: RTL and testbench
===================================

# ttt_board_engine

Datapath and responder for the tic-tac-toe game controller: holds the 3x3 board, the turn owner and the per-turn timer. It executes the controller's one-hot command strobes (create board, check/make move, random move, check winner/full, change turn). It returns the status flags the controller branches on (player_move, time_out, valid_move, winner, full_board). It sits between the controller FSM, the debounced player buttons and the display driver.

## Interface
- TIMEOUT_CYCLES, 750000000: turn length in clk cycles (15 s at 50 MHz); counter width $clog2(TIMEOUT_CYCLES).
- LFSR_SEED, 8'hA5: nonzero reset value of the random-move LFSR.

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- player_one_first, player_two_first  in  1 each  set starting player (0 / 1)
- create_board, start_timer, check_player_move, make_random_move, make_player_move, check_winner, check_full_board, change_turn  in  1 each  controller command strobes, level, at most one high per cycle
- btn_confirm  in  1  debounced single-cycle confirm pulse
- cell_sel  in  4  selected cell index, 0..8 row-major
- player_move  out  1  registered confirm accepted
- time_out  out  1  registered turn-expired pulse
- valid_move  out  1  pending cell legal (combinational)
- winner  out  1  current player owns a line (combinational)
- full_board  out  1  all 9 cells occupied (combinational)
- current_player  out  1  0 = player one (X), 1 = player two (O)
- board_x, board_o  out  9 each  occupancy masks, bit i = cell i
- winner_id  out  2  0 none, 1 player one, 2 player two

## Operation
- Reset: board_x = board_o = 0, current_player = 0, pending_cell = 0, timer = 0, player_move = 0, time_out = 0, winner_id = 0, lfsr = LFSR_SEED.
- player_one_first: current_player <= 0. player_two_first: current_player <= 1.
- create_board: board_x, board_o, winner_id, timer <= 0.
- Confirm: if start_timer && btn_confirm && !player_move, then pending_cell <= cell_sel and player_move <= 1 for one cycle. Confirms outside start_timer are dropped.
- Timer:
  - Increments while start_timer is high and holds otherwise. The ERROR round-trip does not restart the turn.
  - At timer == TIMEOUT_CYCLES-1 with start_timer high: time_out <= 1 for one cycle and timer <= 0.
  - Cleared by change_turn and create_board.
- valid_move = (pending_cell <= 8) && !(board_x | board_o)[pending_cell]. Indices 9..15 are invalid.
- make_random_move: pending_cell <= first empty cell found scanning upward from (lfsr mod 9), wrapping 8 -> 0. The board is never full here. If it were, pending_cell is unchanged.
- make_player_move: writes bit pending_cell of board_x (current_player 0) or board_o (1). The write happens only if the cell is empty and index <= 8; otherwise the board is unchanged.
- winner: the current player's mask covers any of {0,1,2},{3,4,5},{6,7,8},{0,3,6},{1,4,7},{2,5,8},{0,4,8},{2,4,6}. On check_winner with winner high: winner_id <= current_player + 1.
- full_board = &(board_x | board_o).
- change_turn: current_player <= ~current_player.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every cycle and never reaches zero.
- Multiple strobes (illegal) priority: create_board > make_player_move > make_random_move > change_turn > player_*_first.

## Timing
- player_move and time_out: asserted the cycle after the triggering edge, width exactly 1.
- btn_confirm and timeout on the same cycle: player_move wins, time_out is suppressed and the timer holds.
- valid_move, winner, full_board: zero latency from registered state. They are valid during the strobe cycle the controller samples.
- Board and pending_cell updates are visible the cycle after the strobe. The controller's MAKE_MOVE -> CHECK_WINNER ordering therefore sees the new mark.
- Mid-operation reset: all state returns to reset values asynchronously and any pulse in flight is cancelled.

## Test plan
- Reset, then player_two_first, create_board -> current_player = 1; board_x = board_o = 0; winner_id = 0; player_move = time_out = 0.
- start_timer high, cell_sel = 4, btn_confirm pulse -> player_move high exactly 1 cycle later for 1 cycle; check_player_move -> valid_move = 1; make_player_move -> board_o = 9'h010.
- Cell 4 occupied, confirm cell 4 -> valid_move = 0 and board unchanged. Then confirm cell 9 -> valid_move = 0.
- TIMEOUT_CYCLES = 16, start_timer held -> time_out pulses on cycle 16. Dropping start_timer for 3 cycles mid-count delays the pulse by exactly 3 cycles.
- Player one with board_x = 9'h003 and pending_cell = 2: make_player_move -> board_x = 9'h007; check_winner -> winner = 1 and winner_id = 1. Repeat with board_x = 9'h003 on cells 4,5 -> winner = 0.
- Eight cells filled, cell 6 empty: make_random_move for any lfsr value -> pending_cell = 6; make_player_move -> full_board = 1.

Source files
------------

// File: rtl/ttt_board_engine.sv
// Board datapath for the tic-tac-toe controller: 3x3 occupancy masks, turn owner,
// per-turn timer, random-move picker and the status flags the controller branches on.
module ttt_board_engine #(
    parameter int unsigned TIMEOUT_CYCLES = 750000000,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       player_one_first,
    input  logic       player_two_first,
    input  logic       create_board,
    input  logic       start_timer,
    input  logic       check_player_move,
    input  logic       make_random_move,
    input  logic       make_player_move,
    input  logic       check_winner,
    input  logic       check_full_board,
    input  logic       change_turn,
    input  logic       btn_confirm,
    input  logic [3:0] cell_sel,
    output logic       player_move,
    output logic       time_out,
    output logic       valid_move,
    output logic       winner,
    output logic       full_board,
    output logic       current_player,
    output logic [8:0] board_x,
    output logic [8:0] board_o,
    output logic [1:0] winner_id
);

    localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    // Winning lines as cell masks, bit i = cell i (row-major).
    localparam logic [8:0] LINES [8] = '{
        9'b000_000_111, 9'b000_111_000, 9'b111_000_000,
        9'b001_001_001, 9'b010_010_010, 9'b100_100_100,
        9'b100_010_001, 9'b001_010_100
    };

    logic [3:0]    pending_cell;
    logic [TW-1:0] timer;
    logic [7:0]    lfsr;

    logic [8:0]  occupied;
    logic [15:0] occupied_ext;
    logic [8:0]  own_mask;
    logic [8:0]  pending_bit;
    logic        confirm_ok;
    logic        timer_clear;
    logic        timer_last;
    logic        cmd_create;
    logic        cmd_make;
    logic        cmd_random;
    logic        cmd_turn;
    logic        cmd_first;
    logic [3:0]  start_cell;
    logic [4:0]  probe;
    logic [3:0]  random_cell;
    logic        random_found;
    logic        lfsr_fb;

    // The check strobes only mark when the controller samples; the flags are always live.
    logic unused_strobes;
    assign unused_strobes = check_player_move | check_full_board;

    // Illegal overlapping strobes resolve to exactly one effective command.
    assign cmd_create = create_board;
    assign cmd_make   = make_player_move & ~create_board;
    assign cmd_random = make_random_move & ~create_board & ~make_player_move;
    assign cmd_turn   = change_turn & ~create_board & ~make_player_move & ~make_random_move;
    assign cmd_first  = (player_one_first | player_two_first)
                        & ~create_board & ~make_player_move & ~make_random_move & ~change_turn;

    assign occupied     = board_x | board_o;
    assign occupied_ext = {7'b0, occupied};
    assign own_mask     = current_player ? board_o : board_x;
    assign pending_bit  = 9'b1 << pending_cell;

    assign valid_move = (pending_cell <= 4'd8) && !occupied_ext[pending_cell];
    assign full_board = &occupied;

    always_comb begin
        winner = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((own_mask & LINES[i]) == LINES[i]) begin
                winner = 1'b1;
            end
        end
    end

    assign confirm_ok  = start_timer & btn_confirm & ~player_move;
    assign timer_clear = cmd_create | cmd_turn;
    assign timer_last  = (timer == T_LAST);

    // First empty cell scanning upward from lfsr mod 9; the descending loop lets the
    // smallest offset win.
    assign start_cell = 4'(lfsr % 8'd9);

    always_comb begin
        probe        = '0;
        random_found = 1'b0;
        random_cell  = pending_cell;
        for (int k = 8; k >= 0; k--) begin
            probe = 5'(start_cell) + 5'(k);
            if (probe >= 5'd9) begin
                probe = probe - 5'd9;
            end
            if (!occupied_ext[probe[3:0]]) begin
                random_found = 1'b1;
                random_cell  = probe[3:0];
            end
        end
    end

    // A confirm landing on the terminal count wins; the timer then holds so the
    // timeout fires on the next counting cycle instead of being lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer    <= '0;
            time_out <= 1'b0;
        end else begin
            time_out <= start_timer & timer_last & ~confirm_ok & ~timer_clear;
            if (timer_clear) begin
                timer <= '0;
            end else if (start_timer) begin
                if (!timer_last) begin
                    timer <= timer + TW'(1);
                end else if (!confirm_ok) begin
                    timer <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            player_move  <= 1'b0;
            pending_cell <= 4'd0;
        end else begin
            player_move <= confirm_ok;
            if (cmd_random && random_found) begin
                pending_cell <= random_cell;
            end else if (confirm_ok) begin
                pending_cell <= cell_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            board_x <= '0;
            board_o <= '0;
        end else if (cmd_create) begin
            board_x <= '0;
            board_o <= '0;
        end else if (cmd_make && valid_move) begin
            if (current_player) begin
                board_o <= board_o | pending_bit;
            end else begin
                board_x <= board_x | pending_bit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            current_player <= 1'b0;
        end else if (cmd_turn) begin
            current_player <= ~current_player;
        end else if (cmd_first) begin
            current_player <= ~player_one_first;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            winner_id <= 2'd0;
        end else if (cmd_create) begin
            winner_id <= 2'd0;
        end else if (check_winner && winner) begin
            winner_id <= current_player ? 2'd2 : 2'd1;
        end
    end

    // Fibonacci taps 8,6,5,4: maximal length, so a nonzero seed never reaches zero.
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end

endmodule

// File: tb/tb_ttt_board_engine.sv
// Directed bench for ttt_board_engine: a cell-ownership model is advanced every clock
// and compared against all outputs, alongside hand-computed literal expectations.
module tb_ttt_board_engine;

    localparam int T = 16;
    localparam logic [7:0] SEED = 8'hA5;

    localparam int S_P1 = 0, S_P2 = 1, S_CREATE = 2, S_CHECKP = 3, S_RANDOM = 4;
    localparam int S_MAKE = 5, S_CHECKW = 6, S_CHECKF = 7, S_TURN = 8, S_IDLE = 9;

    logic       clk = 1'b0;
    logic       rst;
    logic       player_one_first, player_two_first, create_board, start_timer;
    logic       check_player_move, make_random_move, make_player_move, check_winner;
    logic       check_full_board, change_turn, btn_confirm;
    logic [3:0] cell_sel;
    logic       player_move, time_out, valid_move, winner, full_board, current_player;
    logic [8:0] board_x, board_o;
    logic [1:0] winner_id;

    ttt_board_engine #(.TIMEOUT_CYCLES(T), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst),
        .player_one_first(player_one_first), .player_two_first(player_two_first),
        .create_board(create_board), .start_timer(start_timer),
        .check_player_move(check_player_move), .make_random_move(make_random_move),
        .make_player_move(make_player_move), .check_winner(check_winner),
        .check_full_board(check_full_board), .change_turn(change_turn),
        .btn_confirm(btn_confirm), .cell_sel(cell_sel),
        .player_move(player_move), .time_out(time_out), .valid_move(valid_move),
        .winner(winner), .full_board(full_board), .current_player(current_player),
        .board_x(board_x), .board_o(board_o), .winner_id(winner_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: cell owner 0 = empty, 1 = player one, 2 = player two.
    int         m_cell [9];
    int         m_cur, m_pend, m_tmr, m_wid;
    bit         m_pm, m_to;
    logic [7:0] m_lfsr;

    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic logic [8:0] mask_of(int who);
        logic [8:0] m = '0;
        for (int i = 0; i < 9; i++) if (m_cell[i] == who) m[i] = 1'b1;
        return m;
    endfunction

    function automatic bit m_valid();
        if (m_pend > 8) return 1'b0;
        return m_cell[m_pend] == 0;
    endfunction

    function automatic bit m_win();
        for (int l = 0; l < 8; l++)
            if (m_cell[lines[l][0]] == m_cur + 1 && m_cell[lines[l][1]] == m_cur + 1 &&
                m_cell[lines[l][2]] == m_cur + 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < 9; i++) if (m_cell[i] == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 9; i++) m_cell[i] = 0;
        m_cur = 0; m_pend = 0; m_tmr = 0; m_wid = 0; m_pm = 0; m_to = 0; m_lfsr = SEED;
    endtask

    task automatic m_clock();
        bit acc, clr, won;
        int pend_n, cur_n, tmr_n, wid_n, idx;
        won    = m_win();
        acc    = start_timer && btn_confirm && !m_pm;
        clr    = create_board || (change_turn && !make_player_move && !make_random_move);
        m_to   = start_timer && (m_tmr == T - 1) && !acc && !clr;
        if (clr) tmr_n = 0;
        else if (!start_timer) tmr_n = m_tmr;
        else if (m_tmr == T - 1) tmr_n = acc ? m_tmr : 0;
        else tmr_n = m_tmr + 1;
        pend_n = acc ? int'(cell_sel) : m_pend;
        cur_n  = m_cur;
        wid_n  = m_wid;
        if (create_board) begin
            for (int i = 0; i < 9; i++) m_cell[i] = 0;
            wid_n = 0;
        end else if (make_player_move) begin
            if (m_valid()) m_cell[m_pend] = m_cur + 1;
        end else if (make_random_move) begin
            for (int k = 0; k < 9; k++) begin
                idx = (int'(m_lfsr) % 9 + k) % 9;
                if (m_cell[idx] == 0) begin
                    pend_n = idx;
                    break;
                end
            end
        end else if (change_turn) cur_n = 1 - m_cur;
        else if (player_one_first) cur_n = 0;
        else if (player_two_first) cur_n = 1;
        if (check_winner && won && !create_board) wid_n = m_cur + 1;
        m_pm   = acc;
        m_tmr  = tmr_n;
        m_pend = pend_n;
        m_cur  = cur_n;
        m_wid  = wid_n;
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("player_move", 32'(player_move), 32'(m_pm));
        chk("time_out", 32'(time_out), 32'(m_to));
        chk("valid_move", 32'(valid_move), 32'(m_valid()));
        chk("winner", 32'(winner), 32'(m_win()));
        chk("full_board", 32'(full_board), 32'(m_full()));
        chk("current_player", 32'(current_player), 32'(m_cur));
        chk("board_x", 32'(board_x), 32'(mask_of(1)));
        chk("board_o", 32'(board_o), 32'(mask_of(2)));
        chk("winner_id", 32'(winner_id), 32'(m_wid));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) m_clock();
        else m_reset();
        #1;
        compare_all();
    endtask

    task automatic strobe(int which);
        case (which)
            S_P1:     player_one_first  = 1'b1;
            S_P2:     player_two_first  = 1'b1;
            S_CREATE: create_board      = 1'b1;
            S_CHECKP: check_player_move = 1'b1;
            S_RANDOM: make_random_move  = 1'b1;
            S_MAKE:   make_player_move  = 1'b1;
            S_CHECKW: check_winner      = 1'b1;
            S_CHECKF: check_full_board  = 1'b1;
            S_TURN:   change_turn       = 1'b1;
            default:  ;
        endcase
        step();
        player_one_first = 1'b0; player_two_first = 1'b0; create_board = 1'b0;
        check_player_move = 1'b0; make_random_move = 1'b0; make_player_move = 1'b0;
        check_winner = 1'b0; check_full_board = 1'b0; change_turn = 1'b0;
    endtask

    task automatic confirm(int c);
        start_timer = 1'b1; btn_confirm = 1'b1; cell_sel = 4'(c);
        step();
        btn_confirm = 1'b0; start_timer = 1'b0;
        step();
    endtask

    task automatic place(int c);
        confirm(c);
        strobe(S_MAKE);
    endtask

    int n;

    initial begin
        rst = 1'b0;
        player_one_first = 1'b0; player_two_first = 1'b0; create_board = 1'b0;
        start_timer = 1'b0; check_player_move = 1'b0; make_random_move = 1'b0;
        make_player_move = 1'b0; check_winner = 1'b0; check_full_board = 1'b0;
        change_turn = 1'b0; btn_confirm = 1'b0; cell_sel = 4'd0;
        m_reset();
        #2;
        compare_all();
        chk("reset_board", 32'({board_x, board_o}), 32'd0);
        chk("reset_pulses", 32'({player_move, time_out, winner_id}), 32'd0);
        repeat (2) step();
        rst = 1'b1;

        strobe(S_P2);
        strobe(S_CREATE);
        chk("p2_first_player", 32'(current_player), 32'd1);

        start_timer = 1'b1; btn_confirm = 1'b1; cell_sel = 4'd4;
        step();
        chk("confirm_pulse_hi", 32'(player_move), 32'd1);
        btn_confirm = 1'b0; start_timer = 1'b0;
        step();
        chk("confirm_pulse_lo", 32'(player_move), 32'd0);
        strobe(S_CHECKP);
        chk("valid_cell4", 32'(valid_move), 32'd1);
        strobe(S_MAKE);
        chk("board_o_cell4", 32'(board_o), 32'h010);

        confirm(4);
        strobe(S_CHECKP);
        chk("occupied_invalid", 32'(valid_move), 32'd0);
        strobe(S_MAKE);
        chk("occupied_unchanged", 32'({board_x, board_o}), 32'h010);
        confirm(9);
        chk("cell9_invalid", 32'(valid_move), 32'd0);
        strobe(S_MAKE);
        chk("cell9_unchanged", 32'({board_x, board_o}), 32'h010);

        strobe(S_CREATE);
        start_timer = 1'b1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (time_out) begin n = i; break; end
        end
        chk("timeout_cycles", 32'(n), 32'd16);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 6) start_timer = 1'b0;
            if (i == 9) start_timer = 1'b1;
            step();
            if (time_out) begin n = i; break; end
        end
        chk("timeout_paused", 32'(n), 32'd19);

        strobe(S_CREATE);
        start_timer = 1'b1;
        repeat (15) step();
        btn_confirm = 1'b1; cell_sel = 4'd0;
        step();
        chk("coincide_pm", 32'({player_move, time_out}), 32'b10);
        btn_confirm = 1'b0;
        step();
        chk("coincide_late_to", 32'({player_move, time_out}), 32'b01);
        start_timer = 1'b0;
        step();

        strobe(S_TURN);
        chk("turn_to_p1", 32'(current_player), 32'd0);
        strobe(S_CREATE);
        place(0);
        place(1);
        chk("board_x_003", 32'(board_x), 32'h003);
        place(2);
        chk("board_x_007", 32'(board_x), 32'h007);
        strobe(S_CHECKW);
        chk("winner_row0", 32'(winner), 32'd1);
        chk("winner_id_p1", 32'(winner_id), 32'd1);

        strobe(S_CREATE);
        place(0); place(1); place(4); place(5);
        chk("board_x_033", 32'(board_x), 32'h033);
        strobe(S_CHECKW);
        chk("no_winner", 32'({winner, winner_id}), 32'd0);

        strobe(S_CREATE);
        place(0); place(1); place(2); place(3); place(4); place(5); place(7); place(8);
        chk("board_x_1bf", 32'(board_x), 32'h1BF);
        for (int r = 0; r < 5; r++) begin
            strobe(S_RANDOM);
            chk("random_to_cell6", 32'(valid_move), 32'd1);
            repeat (r + 1) step();
        end
        strobe(S_MAKE);
        strobe(S_CHECKF);
        chk("full_after_random", 32'({full_board, board_x}), 32'h3FF);

        strobe(S_CREATE);
        for (int r = 0; r < 4; r++) begin
            strobe(S_RANDOM);
            strobe(S_MAKE);
            strobe(S_TURN);
            repeat (r) step();
        end

        start_timer = 1'b1; btn_confirm = 1'b1; cell_sel = 4'd3;
        step();
        chk("pre_reset_pm", 32'(player_move), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        m_reset();
        compare_all();
        chk("async_reset_pm", 32'({player_move, board_x, board_o}), 32'd0);
        btn_confirm = 1'b0; start_timer = 1'b0;
        step();
        rst = 1'b1;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
